// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter owning the shared A/B data mux select, with a one-entry output register.
// Optional `MUX_ARBITER_LOCK_EN`: hold ownership for a whole packet (release on the last beat only).
module mux_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_last,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_last,
   output logic             b_ready,
   output logic             s,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   localparam logic PRIO_A = 1'b0;
   localparam logic PRIO_B = 1'b1;

   state_t state, state_nxt;
   logic   prio, prio_nxt;
   logic   s_nxt;
   logic   can_load;
   logic   a_xfer, b_xfer;
   logic   a_release, b_release;
   logic   a_prio_move, b_prio_move;

   // Output slot is free, or is being emptied this cycle
   assign can_load = !out_valid || out_ready;
   assign a_ready  = (state == OWN_A) && can_load;
   assign b_ready  = (state == OWN_B) && can_load;
   assign a_xfer   = a_valid && a_ready;
   assign b_xfer   = b_valid && b_ready;

`ifdef MUX_ARBITER_LOCK_EN
   // Ownership and priority move only at packet boundaries
   assign a_release   = a_xfer && a_last;
   assign b_release   = b_xfer && b_last;
   assign a_prio_move = a_xfer && a_last;
   assign b_prio_move = b_xfer && b_last;
`else
   assign a_release   = a_xfer || !a_valid;
   assign b_release   = b_xfer || !b_valid;
   assign a_prio_move = a_xfer;
   assign b_prio_move = b_xfer;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         prio  <= PRIO_A;
         s     <= 1'b0;
      end else begin
         state <= state_nxt;
         prio  <= prio_nxt;
         s     <= s_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      prio_nxt  = prio;
      s_nxt     = s;
      unique case (state)
         IDLE: begin
            if (a_valid && (!b_valid || prio == PRIO_A)) begin
               state_nxt = OWN_A;
            end else if (b_valid) begin
               state_nxt = OWN_B;
            end
         end
         OWN_A: begin
            if (a_release) begin
               state_nxt = b_valid ? OWN_B : IDLE;
            end
         end
         OWN_B: begin
            if (b_release) begin
               state_nxt = a_valid ? OWN_A : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (a_prio_move) begin
         prio_nxt = PRIO_B;
      end else if (b_prio_move) begin
         prio_nxt = PRIO_A;
      end
      // Select follows the owner; IDLE keeps the last select
      if (state_nxt == OWN_A) begin
         s_nxt = 1'b0;
      end else if (state_nxt == OWN_B) begin
         s_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= WIDTH'(0);
         out_last  <= 1'b0;
      end else if (a_xfer) begin
         out_valid <= 1'b1;
         out_data  <= a_data;
         out_last  <= a_last;
      end else if (b_xfer) begin
         out_valid <= 1'b1;
         out_data  <= b_data;
         out_last  <= b_last;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(a_ready && b_ready));
      end
   end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that shares one 8-bit 2:1 data mux between source A and source B. It grants one owner at a time, drives the mux select `s`, and moves accepted beats into a one-entry output register with a valid/ready handshake. It sits in front of the shared downstream consumer and is the only block allowed to drive the mux select.

## Interface
- `WIDTH`, 8, data width of both sources and the output.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `a_valid` in 1: source A beat present.
- `a_data` in WIDTH: source A beat.
- `a_last` in 1: source A end-of-packet marker.
- `a_ready` out 1: source A beat accepted this cycle when high with `a_valid`.
- `b_valid`, `b_data`, `b_last`, `b_ready`: same as the A signals, for source B.
- `s` out 1: registered mux select. 0 selects A, 1 selects B.
- `out_valid` out 1: output register holds a beat.
- `out_data` out WIDTH: buffered beat.
- `out_last` out 1: buffered end-of-packet marker.
- `out_ready` in 1: consumer takes the beat when high with `out_valid`.

## Operation
- States: IDLE (no owner), OWN_A, OWN_B. A priority pointer `prio` is either A or B; reset value is A.
- `can_load = !out_valid | out_ready`.
- `a_ready = (state==OWN_A) & can_load`. `b_ready` is the mirror for OWN_B. Both are combinational, and at most one is ever high.
- A transfer from X happens when `x_valid & x_ready`. On a transfer:
  - `out_data` and `out_last` load the selected source.
  - `out_valid` sets to 1.
  - `prio` moves to the other source.
- When `out_ready & out_valid` and no transfer occurs, `out_valid` clears to 0.
- IDLE:
  - If `a_valid` and (`!b_valid` or `prio==A`), go to OWN_A.
  - Otherwise, if `b_valid`, go to OWN_B.
  - No transfer occurs in IDLE.
- OWN_X, release condition (default build): either a transfer from X, or `x_valid==0`.
- On release from OWN_X: go to OWN_other if the other source is valid, else go to IDLE.
- Without release, the FSM stays in OWN_X.
- `s` updates with the state: 0 in OWN_A, 1 in OWN_B. In IDLE it holds its last value.
- `out_last` is always passed through from the source, whether or not lock is enabled.
- Reset, including mid-operation, has the following effects:
  - State goes to IDLE and `prio` to A.
  - `s`, `out_valid`, `out_data` and `out_last` all go to 0.
  - Any buffered beat is discarded.

## Timing
- Reset values: `s`=0, `out_valid`=0, `out_data`=0, `out_last`=0. `a_ready` and `b_ready` are 0 because the FSM is in IDLE.
- Arbitration latency from IDLE: a request in cycle n gives ownership in cycle n+1. The earliest transfer is in n+1, and `out_valid` rises in n+2.
- Beat latency from transfer to `out_valid` is 1 cycle.
- Under continuous contention, grants alternate A, B, A, ... with one beat per cycle and no idle cycles, provided `out_ready` stays high.
- When `out_ready` is low and `out_valid` is high, both readies are 0. The owner is held and no beats are lost or duplicated.
- When `a_valid` and `b_valid` rise in the same cycle from IDLE, `prio` decides the winner.

## Configuration
- `MUX_ARBITER_LOCK_EN` defined:
  - The release condition in OWN_X becomes "transfer from X with `x_last==1`".
  - `x_valid==0` no longer releases ownership, so a packet may stall mid-stream while keeping ownership.
  - `prio` updates only on the last beat.
  - Packets from A and B are never interleaved at the output.
- `MUX_ARBITER_LOCK_EN` undefined: arbitration is per beat as in Operation, and the `*_last` inputs affect only `out_last`.

## Test plan
- Reset then single source:
  - Stimulus: `reset` for 2 cycles, then `a_valid`=1 with `a_data`=0x11, `out_ready`=1.
  - Required: OWN_A at cycle 1, `a_ready`=1 at cycle 1, `out_valid`=1 with `out_data`=0x11 at cycle 2, `s`=0.
- Contention round robin:
  - Stimulus: A streams 0xA0..0xA3, B streams 0xB0..0xB3, both continuously valid, `out_ready`=1.
  - Required: output sequence A0 B0 A1 B1 A2 B2 A3 B3, `s` toggling every cycle.
- Backpressure:
  - Stimulus: `out_ready`=0 for 3 cycles with `out_valid`=1 holding 0x5C.
  - Required: both readies 0, `out_data` stays 0x5C, and the next beat appears only after `out_ready`=1.
- Valid drop (default build):
  - Stimulus: OWN_A, then `a_valid`=0 while `b_valid`=1.
  - Required: next state OWN_B and `s`=1 one cycle later.
- Lock (`MUX_ARBITER_LOCK_EN`):
  - Stimulus: A sends 3-beat packet 0x01, 0x02, 0x03 with last on 0x03, while B is valid throughout.
  - Required: output 01 02 03 then B's beats. No B beat appears before `out_last`=1.
- Reset mid-packet:
  - Stimulus: assert `reset` while OWN_B with `out_valid`=1.
  - Required: next cycle `out_valid`=0, `s`=0, state IDLE. When both sources are then valid, A wins first.
